// File: rtl/pc_progress_watchdog.sv
// pc_progress_watchdog
// Monitors the fetch PC of a pipelined core. It flags a stall when the same PC
// is sampled STUCK_LIMIT times in a row after its first appearance. It flags a
// timeout when the sampled-cycle budget runs out. On either event it freezes a
// diagnostic snapshot and holds a sticky halt indication until reset or clear.
//
// Parameter legality: STUCK_LIMIT must be in 1..255, because the repeat counter
// is 8 bits wide. TIMEOUT_CYCLES must be in 1..2^32-1, because cycle_count is
// 32 bits wide. TIMEOUT always fires before cycle_count could wrap.

module pc_progress_watchdog #(
    parameter int unsigned      XLEN           = 32,
    parameter int unsigned      STUCK_LIMIT    = 5,
    parameter int unsigned      TIMEOUT_CYCLES = 10000,
    parameter logic [XLEN-1:0]  RESET_PC       = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            clear,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] instr_in,
    output logic            stuck,
    output logic            timeout,
    output logic            halted,
    output logic [31:0]     cycle_count,
    output logic [XLEN-1:0] snap_pc,
    output logic [XLEN-1:0] snap_instr,
    output logic [31:0]     snap_cycle
);

    localparam logic [7:0]  LIMIT_8    = STUCK_LIMIT[7:0];
    localparam logic [31:0] TIMEOUT_32 = TIMEOUT_CYCLES;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STUCK   = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] last_pc;
    logic [7:0]      rep_cnt;

    // Values this sample would produce. They are committed only in RUN with en=1.
    logic        pc_repeat;
    logic [7:0]  rep_next;
    logic [31:0] cycle_next;
    logic        hit_stall;
    logic        hit_timeout;

    assign pc_repeat = (pc_in == last_pc);
    // The count saturates at the limit. It is compared after the increment, so
    // STUCK_LIMIT=1 trips on the first repeat.
    assign rep_next    = !pc_repeat          ? 8'd0    :
                         (rep_cnt == LIMIT_8) ? rep_cnt : rep_cnt + 8'd1;
    assign cycle_next  = cycle_count + 32'd1;
    assign hit_stall   = (rep_next == LIMIT_8);
    assign hit_timeout = (cycle_next == TIMEOUT_32);

    // Watchdog FSM. It holds the counters, the last PC and the detection snapshot.
    // NOTE: every register here has an asynchronous reset and uses a non-blocking
    // assignment. This makes all state update together at the edge, and makes
    // reset clear the snapshot immediately without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            last_pc     <= RESET_PC;
            rep_cnt     <= 8'd0;
            cycle_count <= 32'd0;
            snap_pc     <= '0;
            snap_instr  <= '0;
            snap_cycle  <= 32'd0;
        end else if (clear) begin
            // Re-arm. This edge performs no sample, even when en is high.
            state       <= ST_RUN;
            last_pc     <= RESET_PC;
            rep_cnt     <= 8'd0;
            cycle_count <= 32'd0;
            snap_pc     <= '0;
            snap_instr  <= '0;
            snap_cycle  <= 32'd0;
        end else if (state == ST_RUN && en) begin
            cycle_count <= cycle_next;
            rep_cnt     <= rep_next;
            last_pc     <= pc_in;
            // Stall wins when both events land on the same sample.
            if (hit_stall) begin
                state      <= ST_STUCK;
                snap_pc    <= pc_in;
                snap_instr <= instr_in;
                snap_cycle <= cycle_next;
            end else if (hit_timeout) begin
                state      <= ST_TIMEOUT;
                snap_pc    <= pc_in;
                snap_instr <= instr_in;
                snap_cycle <= cycle_next;
            end
        end
        // STUCK and TIMEOUT are terminal. Everything stays frozen until reset or clear.
    end

    // The status flags are decoded directly from the state register.
    assign stuck   = (state == ST_STUCK);
    assign timeout = (state == ST_TIMEOUT);
    assign halted  = stuck | timeout;

endmodule

// File: tb/tb_pc_progress_watchdog.sv
// Bench for pc_progress_watchdog.
// Four instances with different limits receive the same stimulus.
// A run-length model tracks each instance and is compared against it on
// every cycle. Literal expectations pin the key points of each scenario.

module tb_pc_progress_watchdog;

    localparam int NI = 4;
    localparam int unsigned LIM [NI] = '{5, 5, 5, 1};
    localparam int unsigned TO  [NI] = '{10000, 20, 6, 10000};

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        clear;
    logic [31:0] pc_in;
    logic [31:0] instr_in;

    logic        d_stuck   [NI];
    logic        d_timeout [NI];
    logic        d_halted  [NI];
    logic [31:0] d_cc      [NI];
    logic [31:0] d_spc     [NI];
    logic [31:0] d_sin     [NI];
    logic [31:0] d_scy     [NI];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_progress_watchdog #(.XLEN(32), .STUCK_LIMIT(5), .TIMEOUT_CYCLES(10000), .RESET_PC(32'h0)) u_dut0 (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .pc_in(pc_in), .instr_in(instr_in),
        .stuck(d_stuck[0]), .timeout(d_timeout[0]), .halted(d_halted[0]), .cycle_count(d_cc[0]),
        .snap_pc(d_spc[0]), .snap_instr(d_sin[0]), .snap_cycle(d_scy[0]));

    pc_progress_watchdog #(.XLEN(32), .STUCK_LIMIT(5), .TIMEOUT_CYCLES(20), .RESET_PC(32'h0)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .pc_in(pc_in), .instr_in(instr_in),
        .stuck(d_stuck[1]), .timeout(d_timeout[1]), .halted(d_halted[1]), .cycle_count(d_cc[1]),
        .snap_pc(d_spc[1]), .snap_instr(d_sin[1]), .snap_cycle(d_scy[1]));

    pc_progress_watchdog #(.XLEN(32), .STUCK_LIMIT(5), .TIMEOUT_CYCLES(6), .RESET_PC(32'h0)) u_dut2 (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .pc_in(pc_in), .instr_in(instr_in),
        .stuck(d_stuck[2]), .timeout(d_timeout[2]), .halted(d_halted[2]), .cycle_count(d_cc[2]),
        .snap_pc(d_spc[2]), .snap_instr(d_sin[2]), .snap_cycle(d_scy[2]));

    pc_progress_watchdog #(.XLEN(32), .STUCK_LIMIT(1), .TIMEOUT_CYCLES(10000), .RESET_PC(32'h0)) u_dut3 (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .pc_in(pc_in), .instr_in(instr_in),
        .stuck(d_stuck[3]), .timeout(d_timeout[3]), .halted(d_halted[3]), .cycle_count(d_cc[3]),
        .snap_pc(d_spc[3]), .snap_instr(d_sin[3]), .snap_cycle(d_scy[3]));

    // Model state. The model tracks the length of the trailing run of equal
    // PCs, counting the reset seed as one occurrence, plus the number of
    // samples taken since reset or clear.
    logic [31:0] m_last [NI];
    int          m_run  [NI];
    int          m_n    [NI];
    bit          m_st   [NI];
    bit          m_to   [NI];
    logic [31:0] m_spc  [NI];
    logic [31:0] m_sin  [NI];
    logic [31:0] m_scy  [NI];

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < NI; i++) begin
            if (reset || clear) begin
                m_last[i] = 32'h0;
                m_run[i]  = 1;
                m_n[i]    = 0;
                m_st[i]   = 1'b0;
                m_to[i]   = 1'b0;
                m_spc[i]  = 32'h0;
                m_sin[i]  = 32'h0;
                m_scy[i]  = 32'h0;
            end else if (en && !(m_st[i] || m_to[i])) begin
                m_n[i]    = m_n[i] + 1;
                m_run[i]  = (pc_in == m_last[i]) ? m_run[i] + 1 : 1;
                m_last[i] = pc_in;
                // A stall needs LIM repeats after the first occurrence.
                if (m_run[i] == int'(LIM[i]) + 1) begin
                    m_st[i] = 1'b1;
                end else if (m_n[i] == int'(TO[i])) begin
                    m_to[i] = 1'b1;
                end
                if (m_st[i] || m_to[i]) begin
                    m_spc[i] = pc_in;
                    m_sin[i] = instr_in;
                    m_scy[i] = 32'(m_n[i]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every instance against the model just after each falling edge.
    always @(negedge clk) begin
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("i%0d stuck", i),       32'(d_stuck[i]),   32'(m_st[i]));
            check($sformatf("i%0d timeout", i),     32'(d_timeout[i]), 32'(m_to[i]));
            check($sformatf("i%0d halted", i),      32'(d_halted[i]),  32'(m_st[i] | m_to[i]));
            check($sformatf("i%0d cycle_count", i), d_cc[i],           32'(m_n[i]));
            check($sformatf("i%0d snap_pc", i),     d_spc[i],          m_spc[i]);
            check($sformatf("i%0d snap_instr", i),  d_sin[i],          m_sin[i]);
            check($sformatf("i%0d snap_cycle", i),  d_scy[i],          m_scy[i]);
        end
    end

    // Drive one cycle of inputs at a falling edge and return at the next falling edge.
    task automatic cyc(input logic e, input logic [31:0] pc, input logic [31:0] ins);
        en       = e;
        pc_in    = pc;
        instr_in = ins;
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1'b1, 32'h0000_0EEE, 32'h0);
        clear = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b1;
        clear    = 1'b0;
        pc_in    = 32'h0;
        instr_in = 32'h0;
        @(negedge clk);

        // Reset held with activity on the inputs.
        repeat (3) cyc(1'b1, $urandom, $urandom);
        check("rst cycle_count", d_cc[0], 32'd0);
        check("rst halted", 32'(d_halted[0]), 32'd0);
        check("rst snap_pc", d_spc[0], 32'd0);
        reset = 1'b0;
        repeat (10) cyc(1'b0, $urandom, $urandom);
        check("idle cycle_count", d_cc[0], 32'd0);
        check("idle stuck", 32'(d_stuck[0]), 32'd0);

        // Stall: 0x4..0x20, then 0x24 held six times.
        for (int k = 1; k <= 8; k++) cyc(1'b1, 32'(4 * k), 32'h13 + 32'(k));
        for (int r = 1; r <= 6; r++) begin
            cyc(1'b1, 32'h24, 32'h0000_006F);
            if (r == 5) check("stall pre stuck", 32'(d_stuck[0]), 32'd0);
        end
        check("stall stuck", 32'(d_stuck[0]), 32'd1);
        check("stall halted", 32'(d_halted[0]), 32'd1);
        check("stall snap_pc", d_spc[0], 32'h24);
        check("stall snap_instr", d_sin[0], 32'h6F);
        check("stall snap_cycle", d_scy[0], 32'd14);
        repeat (2) cyc(1'b1, 32'h28, 32'h0);
        check("stall frozen cycle_count", d_cc[0], 32'd14);
        check("stall frozen snap_pc", d_spc[0], 32'h24);
        check("to6 timeout", 32'(d_timeout[2]), 32'd1);
        check("to6 snap_cycle", d_scy[2], 32'd6);
        check("to6 snap_pc", d_spc[2], 32'h18);
        check("lim1 stuck", 32'(d_stuck[3]), 32'd1);
        check("lim1 snap_cycle", d_scy[3], 32'd10);

        // Clear re-arms. It also carries en=1 and a PC, which must not be sampled.
        do_clear();
        check("clr halted", 32'(d_halted[0]), 32'd0);
        check("clr cycle_count", d_cc[0], 32'd0);
        check("clr snap_pc", d_spc[0], 32'd0);
        check("clr snap_instr", d_sin[0], 32'd0);
        check("clr snap_cycle", d_scy[0], 32'd0);

        // Timeout: 20 distinct PCs into the TIMEOUT_CYCLES=20 instance.
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, 32'h1000 + 32'(4 * k), 32'hA000 + 32'(k));
            if (k == 18) check("to20 pre timeout", 32'(d_timeout[1]), 32'd0);
        end
        check("to20 timeout", 32'(d_timeout[1]), 32'd1);
        check("to20 stuck", 32'(d_stuck[1]), 32'd0);
        check("to20 snap_cycle", d_scy[1], 32'd20);
        check("to20 snap_pc", d_spc[1], 32'h104C);
        check("to20 snap_instr", d_sin[1], 32'hA013);

        // Simultaneous events, with PC held at 0 from reset.
        reset = 1'b1;
        cyc(1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        for (int r = 1; r <= 5; r++) begin
            cyc(1'b1, 32'h0, 32'h13);
            if (r == 4) check("pc0 pre stuck", 32'(d_stuck[2]), 32'd0);
        end
        check("pc0 stuck", 32'(d_stuck[2]), 32'd1);
        check("pc0 timeout", 32'(d_timeout[2]), 32'd0);
        check("pc0 snap_cycle", d_scy[2], 32'd5);
        do_clear();
        for (int r = 1; r <= 6; r++) begin
            cyc(1'b1, 32'h100, 32'h0000_0073);
            if (r == 5) check("pc100 pre stuck", 32'(d_stuck[2]), 32'd0);
        end
        check("tie stuck", 32'(d_stuck[2]), 32'd1);
        check("tie timeout", 32'(d_timeout[2]), 32'd0);
        check("tie snap_cycle", d_scy[2], 32'd6);

        // The repeat count survives an en gap.
        do_clear();
        repeat (4) cyc(1'b1, 32'h200, 32'h33);
        repeat (4) cyc(1'b0, 32'h999, 32'h0);
        check("gap cycle_count", d_cc[0], 32'd4);
        cyc(1'b1, 32'h200, 32'h33);
        check("gap pre stuck", 32'(d_stuck[0]), 32'd0);
        cyc(1'b1, 32'h200, 32'h33);
        check("gap stuck", 32'(d_stuck[0]), 32'd1);
        check("gap snap_cycle", d_scy[0], 32'd6);

        // Asynchronous reset while the repeat count is 4.
        do_clear();
        repeat (5) cyc(1'b1, 32'h300, 32'h44);
        check("mid cycle_count", d_cc[0], 32'd5);
        reset = 1'b1;
        #1;
        check("async cycle_count", d_cc[0], 32'd0);
        check("async stuck", 32'(d_stuck[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int r = 1; r <= 6; r++) begin
            cyc(1'b1, 32'h300, 32'h44);
            if (r == 5) check("post rst pre stuck", 32'(d_stuck[0]), 32'd0);
        end
        check("post rst stuck", 32'(d_stuck[0]), 32'd1);

        @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
